audio_i2s_tx: RTL and testbench

//  I2S transmit serializer downstream of the AXI audio-out register slave.

---
 rtl/audio_i2s_tx_if.sv | 9 +
 rtl/audio_i2s_tx.sv | 89 ++++++++
 tb/tb_audio_i2s_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: valid/ready sample-pair stream into the I2S transmitter
interface audio_i2s_tx_if #(parameter int DATA_WIDTH = 24);
  logic valid;
  logic ready;
  logic [DATA_WIDTH-1:0] left;
  logic [DATA_WIDTH-1:0] right;
  modport master(output valid, left, right, input ready);
  modport slave(input valid, left, right, output ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S serializer fed by a sample-pair FIFO, with BCLK/LRCLK generation
// and underrun pulse; defining I2S_UNDERRUN_CNT_EN adds a saturating underrun_count.
module audio_i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic enable,
  audio_i2s_tx_if.slave s,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic bclk,
  output logic lrclk,
  output logic sdata,
  output logic underrun
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 2 * SLOT_WIDTH;
  localparam int BW = $clog2(FW);
  localparam int CW = BCLK_HALF > 1 ? $clog2(BCLK_HALF) : 1;
  localparam logic [CW-1:0] DMAX = CW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] BMAX = BW'(FW - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] lvl_nxt;
  logic [CW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, nbit;
  logic [FW-1:0] sr, frame;
  logic [SLOT_WIDTH-1:0] slot_l, slot_r;
  logic wrap, fall, fstart, empty, push, pop;
  assign wrap    = div_cnt == DMAX;
  assign fall    = enable && wrap && bclk;
  assign nbit    = bit_cnt == BMAX ? '0 : bit_cnt + 1'b1;
  assign fstart  = fall && bit_cnt == BMAX;
  assign empty   = fifo_level == '0;
  assign push    = s.valid && s.ready;
  assign pop     = fstart && !empty;
  assign lvl_nxt = fifo_level + (AW + 1)'(push) - (AW + 1)'(pop);
  // Each slot: one idle bit after the LRCLK edge, MSB-first sample, zero pad
  assign slot_l  = SLOT_WIDTH'(mem[rp][2*DATA_WIDTH-1:DATA_WIDTH]) << (SLOT_WIDTH - DATA_WIDTH - 1);
  assign slot_r  = SLOT_WIDTH'(mem[rp][DATA_WIDTH-1:0]) << (SLOT_WIDTH - DATA_WIDTH - 1);
  assign frame   = fstart ? (empty ? '0 : {slot_l, slot_r}) : sr;
  always_ff @(posedge ACLK)
    if (push) mem[wp] <= {s.left, s.right};
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      s.ready    <= 1'b1;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= lvl_nxt;
      s.ready    <= lvl_nxt != FULL;
    end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN || !enable) begin
      div_cnt  <= '0;
      bit_cnt  <= BMAX;
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      sr       <= '0;
    end else begin
      div_cnt  <= wrap ? '0 : div_cnt + 1'b1;
      bclk     <= wrap ? ~bclk : bclk;
      underrun <= fstart && empty;
      if (fall) begin
        bit_cnt <= nbit;
        lrclk   <= nbit >= BW'(SLOT_WIDTH);
        sdata   <= frame[FW-1];
        sr      <= {frame[FW-2:0], 1'b0};
      end
    end
`ifdef I2S_UNDERRUN_CNT_EN
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) underrun_count <= '0;
    else if (fstart && empty && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 1'b1;
`endif
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed checks of FIFO, frame format, underrun and enable/reset behaviour
module tb_audio_i2s_tx;
  logic tb_ACLK, tb_ARESETN, enable;
  logic [2:0] fifo_level;
  logic bclk, lrclk, sdata, underrun;
`ifdef I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] pl [5] = '{24'h800001, 24'h5A5A5A, 24'hFFFFFF, 24'h012345, 24'hDEAD00};
  logic [23:0] pr [5] = '{24'h7FFFFE, 24'hC3C3C3, 24'h000001, 24'hFEDCBA, 24'hBEEF00};
  logic [63:0] d, lr;
  int np, sor;
  int p [3];
  audio_i2s_tx_if #(.DATA_WIDTH(24)) s_if ();
  audio_i2s_tx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .BCLK_HALF(2), .FIFO_DEPTH(4)) dut (
    .ACLK(tb_ACLK),
    .ARESETN(tb_ARESETN),
    .enable(enable),
    .s(s_if),
    .fifo_level(fifo_level),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .underrun(underrun)
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );
  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;
  task automatic step(input int n);
    repeat (n) @(posedge tb_ACLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called just after a frame-start edge; samples each bit on the bclk rise
  task automatic capture(output logic [63:0] dat, output logic [63:0] ws);
    for (int n = 0; n < 64; n++) begin
      step(2);
      dat[63-n] = sdata;
      ws[63-n]  = lrclk;
      step(2);
    end
  endtask
  function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction
  initial begin
    tb_ARESETN = 1'b0;
    enable = 1'b0;
    s_if.valid = 1'b0;
    s_if.left = '0;
    s_if.right = '0;
    step(3);
    tb_ARESETN = 1'b1;
    step(1);
    check("rst_level", 64'(fifo_level), 0);
    check("rst_ready", 64'(s_if.ready), 1);
    check("rst_bclk", 64'(bclk), 0);
    s_if.valid = 1'b1;
    s_if.left = 24'hABCDEF;
    s_if.right = 24'h123456;
    step(1);
    s_if.valid = 1'b0;
    check("push_level", 64'(fifo_level), 1);
    enable = 1'b1;
    step(4);
    check("t2_start_level", 64'(fifo_level), 0);
    check("t2_no_underrun", 64'(underrun), 0);
    capture(d, lr);
    check("t2_data", d, 64'h55E6F780_091A2B00);
    check("t2_lrclk", lr, 64'h00000000_FFFFFFFF);
    check("t2_underrun_next", 64'(underrun), 1);
    step(134);
    check("pre_rst_bclk", 64'(bclk), 1);
    check("pre_rst_lrclk", 64'(lrclk), 1);
    tb_ARESETN = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_bclk", 64'(bclk), 0);
    check("arst_lrclk", 64'(lrclk), 0);
    check("arst_sdata", 64'(sdata), 0);
    tb_ARESETN = 1'b1;
    step(1);
    check("rel_level", 64'(fifo_level), 0);
    check("rel_ready", 64'(s_if.ready), 1);
`ifdef I2S_UNDERRUN_CNT_EN
    check("rel_count", 64'(underrun_count), 0);
`endif
    enable = 1'b1;
    np = 0;
    sor = 0;
    for (int c = 1; c <= 770; c++) begin
      step(1);
      if (underrun) begin
        if (np < 3) p[np] = c;
        np++;
      end
      if (sdata) sor++;
    end
    check("t3_pulses", 64'(np), 3);
    check("t3_first", 64'(p[0]), 4);
    check("t3_gap1", 64'(p[1] - p[0]), 256);
    check("t3_gap2", 64'(p[2] - p[1]), 256);
    check("t3_sdata_ones", 64'(sor), 0);
`ifdef I2S_UNDERRUN_CNT_EN
    check("t3_count", 64'(underrun_count), 3);
`endif
    enable = 1'b0;
    step(1);
    check("dis_bclk", 64'(bclk), 0);
    s_if.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_if.left = pl[i];
      s_if.right = pr[i];
      step(1);
    end
    s_if.valid = 1'b0;
    check("t4_full_level", 64'(fifo_level), 4);
    check("t4_full_ready", 64'(s_if.ready), 0);
    enable = 1'b1;
    step(3);
    check("t4_pre_level", 64'(fifo_level), 4);
    step(1);
    check("t4_level", 64'(fifo_level), 3);
    check("t4_ready", 64'(s_if.ready), 1);
    capture(d, lr);
    check("t4_p0", d, fr(pl[0], pr[0]));
    check("t4_level2", 64'(fifo_level), 2);
    capture(d, lr);
    check("t4_p1", d, fr(pl[1], pr[1]));
    check("t4_p1_lrclk", lr, 64'h00000000_FFFFFFFF);
    check("t5_level1", 64'(fifo_level), 1);
    step(40);
    check("t5_bit10", 64'(sdata), 1);
    enable = 1'b0;
    step(1);
    check("t5_off_bclk", 64'(bclk), 0);
    check("t5_off_lrclk", 64'(lrclk), 0);
    check("t5_off_sdata", 64'(sdata), 0);
    check("t5_off_level", 64'(fifo_level), 1);
    enable = 1'b1;
    step(4);
    check("t5_re_level", 64'(fifo_level), 0);
    check("t5_re_underrun", 64'(underrun), 0);
    capture(d, lr);
    check("t5_p3", d, fr(pl[3], pr[3]));
    check("t5_underrun_next", 64'(underrun), 1);
    enable = 1'b0;
    step(1);
`ifdef I2S_UNDERRUN_CNT_EN
    check("t6_count_before", 64'(underrun_count), 4);
    force dut.underrun_count = 16'hFFFE;
    step(1);
    release dut.underrun_count;
    enable = 1'b1;
    step(4);
    check("t6_count_max", 64'(underrun_count), 64'hFFFF);
    step(256);
    check("t6_count_sat1", 64'(underrun_count), 64'hFFFF);
    step(256);
    check("t6_count_sat2", 64'(underrun_count), 64'hFFFF);
    enable = 1'b0;
    step(1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
